// File: rtl/pq_host_ctrl.sv
// Host-side controller for the head cell of the array priority queue: accepts one
// push/pop/drop request at a time, issues it to cell 0, and reports the outcome.
module pq_host_ctrl #(
  parameter int DEPTH  = 8,
  parameter int TW     = 4,
  parameter int PW     = 4,
  parameter int TO_CYC = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [1:0]                 req_op_i,
  input  logic [TW-1:0]              req_id_i,
  input  logic [PW-1:0]              req_prio_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [TW-1:0]              rsp_id_o,
  output logic [PW-1:0]              rsp_prio_o,
  output logic                       rsp_err_o,
  output logic                       push_o,
  output logic                       pop_o,
  output logic                       drop_o,
  output logic [TW-1:0]              cmd_id_o,
  output logic [PW-1:0]              cmd_prio_o,
  input  logic                       push_vld_i,
  input  logic                       pop_vld_i,
  input  logic                       drop_vld_i,
  input  logic [TW-1:0]              pop_id_i,
  input  logic [PW-1:0]              pop_prio_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int TOW = $clog2(TO_CYC+1);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_DROP = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  logic [1:0]     lat_op;
  logic [TW-1:0]  lat_id;
  logic [PW-1:0]  lat_prio;
  logic [TOW-1:0] to_cnt;
  logic [TW-1:0]  hold_id;
  logic [PW-1:0]  hold_prio;
  logic           hold_err;
  logic           req_bad;
  logic           done;
  logic           timeout;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(DEPTH)) ? c : c + CW'(1);
  endfunction

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  assign count_o = count;
  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    push_o      = 1'b0;
    pop_o       = 1'b0;
    drop_o      = 1'b0;
    cmd_id_o    = '0;
    cmd_prio_o  = '0;
    done        = 1'b0;
    timeout     = 1'b0;
    // Requests that can be rejected without touching the array
    req_bad = (req_op_i == 2'b11)
            | ((req_op_i == OP_PUSH) & (full_o  | (req_id_i == '0)))
            | ((req_op_i == OP_POP)  &  empty_o)
            | ((req_op_i == OP_DROP) & (empty_o | (req_id_i == '0)));
    case (state)
      ST_IDLE: begin
        req_ready_o = rst_ni;
        if (req_valid_i) state_next = req_bad ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        push_o     = (lat_op == OP_PUSH);
        pop_o      = (lat_op == OP_POP);
        drop_o     = (lat_op == OP_DROP);
        cmd_id_o   = (lat_op == OP_POP) ? '0 : lat_id;
        cmd_prio_o = (lat_op == OP_PUSH) ? lat_prio : '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        cmd_id_o = (lat_op == OP_DROP) ? lat_id : '0;
        case (lat_op)
          OP_PUSH: done = push_vld_i;
          OP_POP:  done = pop_vld_i;
          OP_DROP: done = drop_vld_i;
          default: done = 1'b0;
        endcase
        timeout = (to_cnt == TOW'(TO_CYC-1));
        if (done || timeout) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rsp_id_o   = (state == ST_RESP) ? hold_id   : '0;
  assign rsp_prio_o = (state == ST_RESP) ? hold_prio : '0;
  assign rsp_err_o  = (state == ST_RESP) ? hold_err  : 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count     <= '0;
      lat_op    <= '0;
      lat_id    <= '0;
      lat_prio  <= '0;
      to_cnt    <= '0;
      hold_id   <= '0;
      hold_prio <= '0;
      hold_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            lat_op    <= req_op_i;
            lat_id    <= req_id_i;
            lat_prio  <= req_prio_i;
            hold_id   <= '0;
            hold_prio <= '0;
            hold_err  <= req_bad;
          end
        end
        ST_ISSUE: to_cnt <= '0;
        ST_WAIT: begin
          to_cnt <= to_cnt + TOW'(1);
          // A matching valid wins over a simultaneous timeout
          if (done) begin
            hold_err <= 1'b0;
            case (lat_op)
              OP_PUSH: count <= sat_inc(count);
              OP_POP: begin
                count     <= sat_dec(count);
                hold_id   <= pop_id_i;
                hold_prio <= pop_prio_i;
              end
              OP_DROP: count <= sat_dec(count);
              default: ;
            endcase
          end else if (timeout) begin
            hold_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
